// File: rtl/ssd1306_ctrl.sv
// SSD1306 power-up sequencer and SPI byte scheduler in front of shift_reg.
// Optional panel clear after display-on is enabled by defining SSD1306_CTRL_CLEAR_EN.
module ssd1306_ctrl #(
    parameter int unsigned VDD_DELAY   = 16,
    parameter int unsigned RST_CYCLES  = 8,
    parameter int unsigned RST_RECOVER = 8,
    parameter int unsigned VBAT_DELAY  = 100
) (
    input  logic       clk_in,
    input  logic       reset,
    output logic       oled_nvcd,
    output logic       oled_nvbat,
    output logic       oled_nrst,
    output logic       oled_dnc,
    output logic       spi_start,
    output logic [7:0] spi_data,
    input  logic       spi_ready,
    input  logic       req_valid,
    input  logic       req_dc,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done
);

    localparam int unsigned VDD_W  = $clog2(VDD_DELAY + 1);
    localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned REC_W  = $clog2(RST_RECOVER + 1);
    localparam int unsigned VBAT_W = $clog2(VBAT_DELAY + 1);

    localparam logic [VDD_W-1:0]  VDD_LAST  = VDD_W'(VDD_DELAY - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(RST_RECOVER - 1);
    localparam logic [VBAT_W-1:0] VBAT_LAST = VBAT_W'(VBAT_DELAY - 1);

    localparam logic [3:0] PWR_OFF   = 4'd0;
    localparam logic [3:0] VDD_WAIT  = 4'd1;
    localparam logic [3:0] RST_LOW   = 4'd2;
    localparam logic [3:0] RST_WAIT  = 4'd3;
    localparam logic [3:0] INIT      = 4'd4;
    localparam logic [3:0] VBAT_WAIT = 4'd5;
    localparam logic [3:0] DISP_ON   = 4'd6;
`ifdef SSD1306_CTRL_CLEAR_EN
    localparam logic [3:0] CLEAR     = 4'd7;
`endif
    localparam logic [3:0] IDLE      = 4'd8;
    localparam logic [3:0] REQ       = 4'd9;

    localparam logic [1:0] PH_SEND = 2'd0;
    localparam logic [1:0] PH_BUSY = 2'd1;
    localparam logic [1:0] PH_DONE = 2'd2;

    logic [3:0]        state;
    logic [1:0]        phase;
    logic [4:0]        rom_idx;
    logic [VDD_W-1:0]  vdd_cnt;
    logic [RST_W-1:0]  rst_cnt;
    logic [REC_W-1:0]  rec_cnt;
    logic [VBAT_W-1:0] vbat_cnt;
`ifdef SSD1306_CTRL_CLEAR_EN
    logic [10:0]       clr_cnt;
`endif
    logic              sending;
    logic              byte_done;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    init_rom = 8'hAE;
            5'd1:    init_rom = 8'hD5;
            5'd2:    init_rom = 8'h80;
            5'd3:    init_rom = 8'hA8;
            5'd4:    init_rom = 8'h3F;
            5'd5:    init_rom = 8'hD3;
            5'd6:    init_rom = 8'h00;
            5'd7:    init_rom = 8'h40;
            5'd8:    init_rom = 8'h8D;
            5'd9:    init_rom = 8'h14;
            5'd10:   init_rom = 8'h20;
            5'd11:   init_rom = 8'h00;
            5'd12:   init_rom = 8'hA1;
            5'd13:   init_rom = 8'hC8;
            5'd14:   init_rom = 8'hDA;
            5'd15:   init_rom = 8'h12;
            5'd16:   init_rom = 8'h81;
            5'd17:   init_rom = 8'hCF;
            5'd18:   init_rom = 8'hD9;
            5'd19:   init_rom = 8'hF1;
            5'd20:   init_rom = 8'hDB;
            5'd21:   init_rom = 8'h40;
            5'd22:   init_rom = 8'hA4;
            5'd23:   init_rom = 8'hA6;
            default: init_rom = 8'h00;
        endcase
    endfunction

    always_comb begin
        sending = (state == INIT) || (state == DISP_ON) || (state == REQ);
`ifdef SSD1306_CTRL_CLEAR_EN
        if (state == CLEAR) sending = 1'b1;
`endif
    end

    // Start is gated by spi_ready combinationally so it can never fire into a busy shifter.
    always_comb begin
        spi_start = sending && (phase == PH_SEND) && spi_ready;
        byte_done = sending && (phase == PH_DONE) && spi_ready;
        req_ready = (state == IDLE) && spi_ready;
        init_done = (state == IDLE) || (state == REQ);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= PWR_OFF;
            phase      <= PH_SEND;
            rom_idx    <= '0;
            vdd_cnt    <= '0;
            rst_cnt    <= '0;
            rec_cnt    <= '0;
            vbat_cnt   <= '0;
`ifdef SSD1306_CTRL_CLEAR_EN
            clr_cnt    <= '0;
`endif
            oled_nvcd  <= 1'b1;
            oled_nvbat <= 1'b1;
            oled_nrst  <= 1'b1;
            oled_dnc   <= 1'b0;
            spi_data   <= '0;
        end else begin
            if (spi_start) begin
                phase <= PH_BUSY;
            end else if (sending && (phase == PH_BUSY)) begin
                phase <= PH_DONE;
            end

            case (state)
                PWR_OFF: begin
                    oled_nvcd <= 1'b0;
                    state     <= VDD_WAIT;
                end
                VDD_WAIT: begin
                    if (vdd_cnt == VDD_LAST) begin
                        oled_nrst <= 1'b0;
                        state     <= RST_LOW;
                    end else begin
                        vdd_cnt <= vdd_cnt + VDD_W'(1);
                    end
                end
                RST_LOW: begin
                    if (rst_cnt == RST_LAST) begin
                        oled_nrst <= 1'b1;
                        state     <= RST_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                RST_WAIT: begin
                    if (rec_cnt == REC_LAST) begin
                        state    <= INIT;
                        phase    <= PH_SEND;
                        rom_idx  <= '0;
                        spi_data <= init_rom(5'd0);
                        oled_dnc <= 1'b0;
                    end else begin
                        rec_cnt <= rec_cnt + REC_W'(1);
                    end
                end
                INIT: begin
                    if (byte_done) begin
                        if (rom_idx == 5'd23) begin
                            oled_nvbat <= 1'b0;
                            state      <= VBAT_WAIT;
                        end else begin
                            rom_idx  <= rom_idx + 5'd1;
                            spi_data <= init_rom(rom_idx + 5'd1);
                            phase    <= PH_SEND;
                        end
                    end
                end
                VBAT_WAIT: begin
                    if (vbat_cnt == VBAT_LAST) begin
                        state    <= DISP_ON;
                        phase    <= PH_SEND;
                        spi_data <= 8'hAF;
                        oled_dnc <= 1'b0;
                    end else begin
                        vbat_cnt <= vbat_cnt + VBAT_W'(1);
                    end
                end
                DISP_ON: begin
                    if (byte_done) begin
`ifdef SSD1306_CTRL_CLEAR_EN
                        state    <= CLEAR;
                        phase    <= PH_SEND;
                        clr_cnt  <= '0;
                        spi_data <= '0;
                        oled_dnc <= 1'b1;
`else
                        state    <= IDLE;
`endif
                    end
                end
`ifdef SSD1306_CTRL_CLEAR_EN
                CLEAR: begin
                    if (byte_done) begin
                        if (clr_cnt == 11'd1023) begin
                            state <= IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 11'd1;
                            phase   <= PH_SEND;
                        end
                    end
                end
`endif
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state    <= REQ;
                        phase    <= PH_SEND;
                        spi_data <= req_data;
                        oled_dnc <= req_dc;
                    end
                end
                REQ: begin
                    if (byte_done) state <= IDLE;
                end
                default: state <= PWR_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_ctrl.sv
// Self-checking bench for ssd1306_ctrl: event-timeline model of power-up, init bytes and requester traffic.
module tb_ssd1306_ctrl;

    localparam int VDD = 4, RSTC = 3, REC = 2, VBAT = 5;
    // Hand-derived for 4/3/2/5: nvcd falls at 1, nrst low 5..7, first start at 10.
    localparam int T_NRST_F = 5;
    localparam int T_NRST_R = 8;
    localparam int T_FIRST  = 10;
`ifdef SSD1306_CTRL_CLEAR_EN
    localparam int N_INIT = 25 + 1024;
`else
    localparam int N_INIT = 25;
`endif

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       oled_nvcd, oled_nvbat, oled_nrst, oled_dnc, spi_start;
    logic [7:0] spi_data;
    logic       spi_ready = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_dc = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done;

    ssd1306_ctrl #(
        .VDD_DELAY(VDD), .RST_CYCLES(RSTC), .RST_RECOVER(REC), .VBAT_DELAY(VBAT)
    ) dut (
        .clk_in(clk_in), .reset(reset),
        .oled_nvcd(oled_nvcd), .oled_nvbat(oled_nvbat), .oled_nrst(oled_nrst),
        .oled_dnc(oled_dnc), .spi_start(spi_start), .spi_data(spi_data),
        .spi_ready(spi_ready), .req_valid(req_valid), .req_dc(req_dc),
        .req_data(req_data), .req_ready(req_ready), .init_done(init_done)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] rom [24] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                             8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                             8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6};

    int n_checks = 0, n_errors = 0;
    int t = 0;
    logic [8:0] expq [$];
    logic [8:0] src  [$];
    int  n_done, n_starts, n_cmd, st, next_start, nvbat_fall, done_rise, pushed;
    bit  in_flight, pending, rst_prev = 1'b1, accepted, start_seen, rand_busy;
    int  busy = 0, busy_len = 8;
    logic [7:0] cur_data;
    logic       cur_dc;
    bit  nxt_reset = 1'b1, nxt_valid = 1'b0, nxt_dc = 1'b0;
    logic [7:0] nxt_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    task automatic model_clear();
        expq.delete();
        for (int i = 0; i < 24; i++) expq.push_back({1'b0, rom[i]});
        expq.push_back({1'b0, 8'hAF});
`ifdef SSD1306_CTRL_CLEAR_EN
        for (int i = 0; i < 1024; i++) expq.push_back({1'b1, 8'h00});
`endif
        n_done = 0; n_starts = 0; n_cmd = 0; in_flight = 0; pending = 0;
        next_start = T_FIRST; nvbat_fall = -1; done_rise = -1;
    endtask

    task automatic check_cycle();
        bit exp_rr, exp_done;
        logic [8:0] e;
        if (rst_prev) begin
            model_clear();
            t = 0;
            chk("rst_spi_data", spi_data, 0);
            chk("rst_dnc", oled_dnc, 0);
        end else begin
            t++;
        end
        exp_done = (done_rise >= 0) && (t >= done_rise);
        exp_rr   = exp_done && spi_ready && !pending;
        chk("nvcd", oled_nvcd, (t < 1));
        chk("nrst", oled_nrst, !(t >= T_NRST_F && t < T_NRST_R));
        chk("nvbat", oled_nvbat, !(nvbat_fall >= 0 && t >= nvbat_fall));
        chk("init_done", init_done, exp_done);
        chk("req_ready", req_ready, exp_rr);
        chk("spi_start", spi_start, (t == next_start));
        if (spi_start) chk("start_while_busy", spi_ready, 1);
        if (in_flight) begin
            chk("hold_data", spi_data, cur_data);
            chk("hold_dnc", oled_dnc, cur_dc);
        end
        if (in_flight && t >= st + 2 && spi_ready) begin
            in_flight = 0;
            n_done++;
            if (n_done < N_INIT) begin
                if (n_done == 24) begin
                    nvbat_fall = t + 1;
                    next_start = t + 1 + VBAT;
                end else begin
                    next_start = t + 1;
                end
            end else if (n_done == N_INIT) begin
                done_rise = t + 1;
                chk("init_cmd_count", n_cmd, 25);
            end else begin
                pending = 0;
            end
        end
        if (spi_start) begin
            if (n_starts == 0) begin
                chk("first_start_cycle", t, 10);
                chk("first_byte", spi_data, 8'hAE);
            end
            if (n_done == 24) chk("af_gap_after_nvbat", t - nvbat_fall, 5);
            if (n_done < N_INIT && !oled_dnc) n_cmd++;
            if (expq.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("byte_data", spi_data, e[7:0]);
                chk("byte_dnc", oled_dnc, e[8]);
            end
            in_flight = 1; st = t; next_start = -1; n_starts++;
            cur_data = spi_data; cur_dc = oled_dnc;
            busy_len = rand_busy ? int'($urandom_range(1, 10)) : 8;
        end
        if (req_valid && exp_rr) begin
            expq.push_back({req_dc, req_data});
            pending = 1;
            next_start = t + 1;
        end
        accepted   = req_valid && req_ready;
        start_seen = spi_start;
        rst_prev   = reset;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        if (start_seen) busy = busy_len;
        else if (busy > 0) busy--;
        spi_ready = (busy == 0);
        reset     = nxt_reset;
        req_valid = nxt_valid;
        req_data  = nxt_data;
        req_dc    = nxt_dc;
        @(negedge clk_in);
        check_cycle();
    endtask

    // Requester holds valid and data until accepted; optional random gaps between bytes.
    task automatic drive(input bit gaps);
        if (accepted) void'(src.pop_front());
        if (req_valid && !accepted) begin
            nxt_valid = 1'b1;
        end else if (src.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            nxt_valid = 1'b1;
            nxt_data  = src[0][7:0];
            nxt_dc    = src[0][8];
        end else begin
            nxt_valid = 1'b0;
            nxt_data  = 8'($urandom);
            nxt_dc    = 1'($urandom);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL timeout_%s at t=%0d: got no event, expected event within bound", name, t);
    endtask

    initial begin
        int guard;
        rand_busy = 0;
        src.push_back({1'b1, 8'h5A});
        pushed = 1;
        repeat (3) begin drive(0); step(); end
        nxt_reset = 1'b0;

        guard = 0;
        while (!(in_flight && n_done == 10 && !spi_ready && t > st + 1) && guard < 2000) begin
            drive(0); step(); guard++;
        end
        if (guard >= 2000) timeout("byte10");
        nxt_reset = 1'b1;
        drive(0); step();
        nxt_reset = 1'b0;
        drive(0); step();
        chk("midrst_nvcd", oled_nvcd, 1);
        chk("midrst_nvbat", oled_nvbat, 1);
        chk("midrst_nrst", oled_nrst, 1);
        chk("midrst_init_done", init_done, 0);

        guard = 0;
        while (n_done < N_INIT + 1 && guard < 30000) begin
            drive(0); step(); guard++;
        end
        if (guard >= 30000) timeout("first_request");

        src.push_back({1'b0, 8'h01});
        src.push_back({1'b0, 8'h02});
        src.push_back({1'b0, 8'h03});
        pushed += 3;
        guard = 0;
        while (n_done < N_INIT + 4 && guard < 500) begin
            drive(0); step(); guard++;
        end
        if (guard >= 500) timeout("back_to_back");

        rand_busy = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && src.size() < 4) begin
                src.push_back(9'($urandom));
                pushed++;
            end
            drive(1); step();
        end
        guard = 0;
        while ((src.size() > 0 || in_flight || pending || req_valid) && guard < 2000) begin
            drive(0); step(); guard++;
        end
        if (guard >= 2000) timeout("drain");
        repeat (3) begin drive(0); step(); end
        chk("queue_empty", expq.size(), 0);
        chk("bytes_sent", n_done, N_INIT + pushed);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
